// File: rtl/seq_multiplier_if.sv
// Request/result bundle for seq_multiplier: operands and mode in, busy/done/product/overflow out.
// start is taken on any rising edge where busy is low (no other ready signal); done is a one-cycle strobe with no backpressure.
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic                   overflow;
    logic [1:0]             dbg_state;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product, overflow, dbg_state
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product, overflow, dbg_state
    );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one adder reused over WIDTH cycles, signed/unsigned,
// full 2*WIDTH product and a "does not fit in WIDTH bits" flag.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_multiplier_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mult_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 neg_q;
    logic                 sm_q;
    logic [2*WIDTH-1:0]   product_q;
    logic                 overflow_q;
    logic                 done_q;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   res;
    logic [WIDTH:0]       res_top;
    logic                 res_ovf;

    // Operands are stored as magnitudes; the sign is reapplied once at the end.
    always_comb begin
        a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        res     = neg_q ? -acc_q : acc_q;
        res_top = res[2*WIDTH-1:WIDTH-1];
        res_ovf = sm_q ? !((&res_top) || !(|res_top)) : (|res[2*WIDTH-1:WIDTH]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == LAST) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.done      = done_q;
        bus.product   = product_q;
        bus.overflow  = overflow_q;
        bus.dbg_state = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q    <= '0;
            mult_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            sm_q       <= 1'b0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mcand_q <= {{WIDTH{1'b0}}, a_mag};
                        mult_q  <= b_mag;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sm_q    <= bus.signed_mode;
                        neg_q   <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    end
                end
                CALC: begin
                    // Multiplicand walks left while the multiplier bits are consumed LSB first.
                    if (mult_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q <= mcand_q << 1;
                    mult_q  <= mult_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                end
                FINISH: begin
                    product_q  <= res;
                    overflow_q <= res_ovf;
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed cases, handshake corner cases and random operands
// compared against an arithmetic reference model, on WIDTH=8 and WIDTH=16 instances.
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(8))  bus8();
  seq_multiplier_if #(.WIDTH(16)) bus16();

  seq_multiplier #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  seq_multiplier #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer multiply of the operand values in the chosen mode.
  function automatic void model(input int w, input bit sm, input longint a, input longint b,
                                output logic [63:0] prod, output bit ovf);
    longint full, half, pa, pb, p;
    full = longint'(1) << w;
    half = full >> 1;
    pa = a;
    pb = b;
    if (sm && pa >= half) pa = pa - full;
    if (sm && pb >= half) pb = pb - full;
    p = pa * pb;
    prod = 64'(p) & 64'((full * full) - 1);
    ovf = sm ? (p < -half || p > half - 1) : (p > full - 1);
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: pick8 = 8'h00;
      1: pick8 = 8'h80;
      2: pick8 = 8'hFF;
      3: pick8 = 8'h7F;
      default: pick8 = 8'($urandom);
    endcase
  endfunction

  task automatic do_op8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output logic ovf, output int lat,
                        output int busy_n, output bit got);
    bus8.signed_mode = sm;
    bus8.a = a;
    bus8.b = b;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a = 8'($urandom);
    bus8.b = 8'($urandom);
    bus8.signed_mode = 1'($urandom);
    lat = 0; busy_n = 0; got = 0;
    while (!got && lat < 40) begin
      if (bus8.busy) busy_n++;
      @(posedge clk); #1;
      lat++;
      if (bus8.done) got = 1;
    end
    p = bus8.product;
    ovf = bus8.overflow;
  endtask

  task automatic do_op16(input bit sm, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output logic ovf, output int lat,
                         output int busy_n, output bit got);
    bus16.signed_mode = sm;
    bus16.a = a;
    bus16.b = b;
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    bus16.a = 16'($urandom);
    bus16.b = 16'($urandom);
    lat = 0; busy_n = 0; got = 0;
    while (!got && lat < 60) begin
      if (bus16.busy) busy_n++;
      @(posedge clk); #1;
      lat++;
      if (bus16.done) got = 1;
    end
    p = bus16.product;
    ovf = bus16.overflow;
  endtask

  initial begin
    logic [15:0] p8;
    logic [31:0] p16;
    logic        ovf;
    logic [63:0] mp;
    bit          movf;
    int          lat, busy_n;
    bit          got;
    int          n_done;
    int          done_at[$];
    logic [15:0] done_p[$];
    logic [16:0] exp_v;
    bit          sm;
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb;

    bus8.start = 0; bus8.signed_mode = 0; bus8.a = 0; bus8.b = 0;
    bus16.start = 0; bus16.signed_mode = 0; bus16.a = 0; bus16.b = 0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus8.busy), 64'd0);
    check("rst_done", 64'(bus8.done), 64'd0);
    check("rst_product", 64'(bus8.product), 64'd0);
    check("rst_overflow", 64'(bus8.overflow), 64'd0);
    check("rst_state", 64'(bus8.dbg_state), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned 12*10: latency and busy window
    do_op8(1'b0, 8'd12, 8'd10, p8, ovf, lat, busy_n, got);
    check("u12x10_got_done", 64'(got), 64'd1);
    check("u12x10_latency", 64'(lat), 64'd9);
    check("u12x10_busy_cycles", 64'(busy_n), 64'd9);
    check("u12x10_product", 64'(p8), 64'h0078);
    check("u12x10_overflow", 64'(ovf), 64'd0);
    check("u12x10_busy_at_done", 64'(bus8.busy), 64'd0);
    @(posedge clk); #1;
    check("u12x10_done_single", 64'(bus8.done), 64'd0);
    check("u12x10_product_held", 64'(bus8.product), 64'h0078);

    // Directed products
    do_op8(1'b0, 8'd255, 8'd255, p8, ovf, lat, busy_n, got);
    check("u255x255_product", 64'(p8), 64'hFE01);
    check("u255x255_overflow", 64'(ovf), 64'd1);
    do_op8(1'b1, 8'hFD, 8'h05, p8, ovf, lat, busy_n, got);
    check("s_m3x5_product", 64'(p8), 64'hFFF1);
    check("s_m3x5_overflow", 64'(ovf), 64'd0);
    do_op8(1'b1, 8'h80, 8'h80, p8, ovf, lat, busy_n, got);
    check("s_m128sq_product", 64'(p8), 64'h4000);
    check("s_m128sq_overflow", 64'(ovf), 64'd1);
    do_op8(1'b1, 8'h80, 8'h01, p8, ovf, lat, busy_n, got);
    check("s_m128x1_product", 64'(p8), 64'hFF80);
    check("s_m128x1_overflow", 64'(ovf), 64'd0);

    // 7*6 with start re-asserted during CALC and held through the done cycle
    bus8.signed_mode = 1'b0; bus8.a = 8'd7; bus8.b = 8'd6; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    n_done = 0;
    for (int i = 1; i <= 30; i++) begin
      bus8.start = (i >= 4 && i <= 10);
      bus8.a = 8'd2; bus8.b = 8'd2;
      @(posedge clk); #1;
      if (bus8.done) begin
        n_done++;
        done_at.push_back(i);
        done_p.push_back(bus8.product);
      end
    end
    bus8.start = 1'b0;
    check("b2b_done_count", 64'(n_done), 64'd2);
    if (done_at.size() == 2) begin
      check("b2b_first_at", 64'(done_at[0]), 64'd9);
      check("b2b_first_product", 64'(done_p[0]), 64'd42);
      check("b2b_second_at", 64'(done_at[1]), 64'd19);
      check("b2b_second_product", 64'(done_p[1]), 64'd4);
    end

    // Reset asserted mid-CALC
    bus8.signed_mode = 1'b0; bus8.a = 8'd100; bus8.b = 8'd3; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("midrst_busy_before", 64'(bus8.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus8.busy), 64'd0);
    check("midrst_done", 64'(bus8.done), 64'd0);
    check("midrst_product", 64'(bus8.product), 64'd0);
    check("midrst_state", 64'(bus8.dbg_state), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus8.done) n_done++;
    end
    check("midrst_no_done", 64'(n_done), 64'd0);
    do_op8(1'b0, 8'd0, 8'd200, p8, ovf, lat, busy_n, got);
    check("u0x200_product", 64'(p8), 64'd0);
    check("u0x200_overflow", 64'(ovf), 64'd0);

    // Random operands against the reference model
    for (int n = 0; n < 24; n++) begin
      sm = 1'($urandom);
      ra = pick8();
      rb = pick8();
      model(8, sm, longint'(ra), longint'(rb), mp, movf);
      exp_q.push_back({movf, mp[15:0]});
      do_op8(sm, ra, rb, p8, ovf, lat, busy_n, got);
      exp_v = exp_q.pop_front();
      check($sformatf("rnd8_%0d_%s_%0h_%0h", n, sm ? "s" : "u", ra, rb), 64'({got, ovf, p8}), 64'({1'b1, exp_v}));
    end

    // WIDTH=16 instance
    do_op16(1'b1, 16'h8000, 16'h7FFF, p16, ovf, lat, busy_n, got);
    check("w16_latency", 64'(lat), 64'd17);
    check("w16_busy_cycles", 64'(busy_n), 64'd17);
    check("w16_product", 64'(p16), 64'hC0008000);
    check("w16_overflow", 64'(ovf), 64'd1);
    for (int n = 0; n < 8; n++) begin
      sm = 1'($urandom);
      wa = 16'($urandom);
      wb = (n < 2) ? 16'h0001 : 16'($urandom);
      model(16, sm, longint'(wa), longint'(wb), mp, movf);
      do_op16(sm, wa, wb, p16, ovf, lat, busy_n, got);
      check($sformatf("rnd16_%0d_%s_%0h_%0h", n, sm ? "s" : "u", wa, wb), 64'({got, ovf, p16}), {31'd0, 1'b1, movf, mp[31:0]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
